gate_bist: RTL and testbench
============================

GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 10, giving the clocks each input vector is held before its response is sampled; legal range 1..255.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the settle counter; it SHALL satisfy 2^CNT_W > SETTLE_CYCLES.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge except for reset.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  run request, sampled in IDLE or DONE only.
REQ-006 expected  input  4  expected gate output per vector, bit i for vector i; captured on accepted start.
REQ-007 ans  input  1  output of the 2-input gate under test.
REQ-008 a  output  1  gate input A.
REQ-009 b  output  1  gate input B.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from run completion until the next accepted start or reset.
REQ-012 pass  output  1  high when done=1 and fail_mask=0; SHALL be 0 otherwise.
REQ-013 fail_mask  output  4  bit i set when the vector i response mismatched.
REQ-014 fail_count  output  3  number of mismatching vectors, 0..4.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SETTLE, CHECK, DONE.
REQ-016 Vector index idx (2 bits) SHALL drive a=idx[0], b=idx[1], giving the order {a,b}: 00, 10, 01, 11.
REQ-017 In IDLE or DONE, start=1 SHALL perform all of the following: capture expected, clear fail_mask and fail_count, set idx=0, set cnt=0, clear done, enter SETTLE.
REQ-018 In SETTLE, cnt SHALL increment each clock; when cnt==SETTLE_CYCLES-1 the FSM SHALL enter CHECK.
REQ-019 In CHECK, ans SHALL be compared with the captured expected[idx]; on mismatch, fail_mask[idx] SHALL be set and fail_count SHALL increment.
REQ-020 In CHECK with idx<3, the block SHALL increment idx, set cnt=0 and return to SETTLE.
REQ-021 In CHECK with idx==3, the block SHALL enter DONE.
REQ-022 Each vector SHALL occupy exactly SETTLE_CYCLES+1 clocks.
REQ-023 done SHALL rise 4*(SETTLE_CYCLES+1) clocks after the accepting start edge.
REQ-024 busy SHALL be 1 in SETTLE and CHECK and 0 in IDLE and DONE.
REQ-025 start while busy=1 SHALL be ignored, and the captured expected SHALL remain unchanged.
REQ-026 a and b SHALL change only on the entry to SETTLE and SHALL be stable throughout SETTLE and CHECK.
REQ-027 In DONE without start, a, b, fail_mask, fail_count and pass SHALL hold their values.
REQ-028 start in DONE SHALL restart immediately with no intermediate IDLE cycle.
REQ-029 Changes on the expected input while busy=1 SHALL have no effect on the run.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state=IDLE, idx=0, cnt=0, a=0, b=0, busy=0, done=0, pass=0, fail_mask=0, fail_count=0, captured expected=0.
REQ-031 Reset asserted mid-run SHALL abort the run with no partial result retained.
REQ-032 After rst_n deasserts, the first start SHALL begin a fresh run.

Verification
REQ-033 Correct NOR model on ans, expected=4'b0001, SETTLE_CYCLES=10, one-cycle start -> done=1 exactly 44 clocks later, pass=1, fail_mask=0000, fail_count=0.
REQ-034 ans stuck at 0, expected=4'b0001 -> fail_mask=0001, fail_count=1, pass=0.
REQ-035 ans stuck at 1, expected=4'b0001 -> fail_mask=1110, fail_count=3, pass=0.
REQ-036 Bench checks {a,b} per window: 00, 10, 01, 11, each stable for 11 clocks; start pulsed and expected changed to 4'b1111 mid-run -> run unaffected, result per REQ-033.
REQ-037 rst_n pulsed low during vector 2 -> all outputs 0 immediately (asynchronously), state IDLE; a subsequent start completes a clean pass.
REQ-038 After a failing run (fail_mask=1110), a start from DONE with a correct model -> fail_mask cleared on the start edge, final pass=1.

Source files
------------

// File: rtl/gate_bist.sv
// Built-in self test for a 2-input gate: walks the four input vectors,
// waits for the gate to settle, then compares each response with its expected bit.
module gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 10,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       expected,
    input  logic             ans,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_mask,
    output logic [2:0]       fail_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       exp_q;

    logic             mismatch;
    logic [3:0]       idx_bit;
    logic [1:0]       idx_inc;
    logic [3:0]       mask_nxt;
    logic [2:0]       count_nxt;

    always_comb begin
        mismatch  = (ans != exp_q[idx]);
        idx_bit   = 4'b0001 << idx;
        idx_inc   = idx + 2'd1;
        mask_nxt  = mismatch ? (fail_mask | idx_bit) : fail_mask;
        count_nxt = fail_count + {2'b00, mismatch};
    end

    // The gate inputs are registered copies of idx so they only move
    // on the clock that enters SETTLE for the next vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            exp_q      <= 4'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= 4'd0;
            fail_count <= 3'd0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        exp_q      <= expected;
                        fail_mask  <= 4'd0;
                        fail_count <= 3'd0;
                        idx        <= 2'd0;
                        cnt        <= '0;
                        a          <= 1'b0;
                        b          <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    fail_mask  <= mask_nxt;
                    fail_count <= count_nxt;
                    if (idx == 2'd3) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mask_nxt == 4'd0);
                        state <= DONE;
                    end else begin
                        idx   <= idx_inc;
                        a     <= idx_inc[0];
                        b     <= idx_inc[1];
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: directed runs against NOR and stuck-at
// gate models, window/stability checks, mid-run reset and restart from DONE.
module tb_gate_bist;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] expected;
    logic       ans;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [2:0] fail_count;

    // 0: correct NOR, 1: stuck at 0, 2: stuck at 1
    logic [1:0] mode;

    assign ans = (mode == 2'd0) ? ~(a | b) : (mode == 2'd2);

    gate_bist #(
        .SETTLE_CYCLES(10),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .expected(expected),
        .ans(ans),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .pass(pass),
        .fail_mask(fail_mask),
        .fail_count(fail_count)
    );

    typedef struct {
        logic [3:0] mask;
        logic [2:0] cnt;
        logic       pass;
        int         start_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic done_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every rising done is matched against the oldest pending run.
    always @(negedge clk) begin
        if (rst_n && done && !done_q) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("sb_latency", cyc - e_mon.start_cyc, 44);
                check("sb_fail_mask", {28'd0, fail_mask}, {28'd0, e_mon.mask});
                check("sb_fail_count", {29'd0, fail_count}, {29'd0, e_mon.cnt});
                check("sb_pass", {31'd0, pass}, {31'd0, e_mon.pass});
            end
        end
        done_q <= done;
    end

    // Returns at the negedge right after the accepting start edge.
    task automatic pulse_start(input bit push, input logic [3:0] m,
                               input logic [2:0] c, input logic p);
        @(negedge clk);
        start = 1'b1;
        if (push) sb.push_back('{m, c, p, cyc + 1});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] w;
        logic       win_bad [4];
        logic       ctl_bad;

        rst_n    = 1'b0;
        start    = 1'b0;
        expected = 4'b0001;
        mode     = 2'd0;

        @(negedge clk);
        check("reset_outputs", {a, b, busy, done, pass, fail_mask, fail_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
        check("idle_outputs", {a, b, busy, done, pass, fail_mask, fail_count}, 0);

        // Correct NOR gate
        pulse_start(1'b1, 4'b0000, 3'd0, 1'b1);
        check("t1_busy", {busy, done}, {1'b1, 1'b0});
        wait_done("t1_done");
        idle_cycles(5);
        check("t1_hold", {a, b, busy, done, pass, fail_mask, fail_count},
              {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 3'd0});

        // Stuck at 0, restarted straight from DONE
        mode = 2'd1;
        pulse_start(1'b1, 4'b0001, 3'd1, 1'b0);
        check("t2_restart", {busy, done, pass, fail_mask, a, b},
              {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0});
        wait_done("t2_done");

        // Stuck at 1
        mode = 2'd2;
        pulse_start(1'b1, 4'b1110, 3'd3, 1'b0);
        wait_done("t3_done");
        idle_cycles(4);
        check("t3_hold", {done, pass, fail_mask, fail_count, a, b},
              {1'b1, 1'b0, 4'b1110, 3'd3, 1'b1, 1'b1});

        // Restart from a failing DONE with a good gate
        mode = 2'd0;
        pulse_start(1'b1, 4'b0000, 3'd0, 1'b1);
        check("t4_clear", {done, pass, fail_mask, fail_count},
              {1'b0, 1'b0, 4'b0000, 3'd0});
        wait_done("t4_done");

        // Vector windows, with a stray start and expected change mid-run
        pulse_start(1'b1, 4'b0000, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) win_bad[i] = 1'b0;
        ctl_bad = 1'b0;
        for (int k = 0; k < 44; k++) begin
            w = 2'(k / 11);
            if (a !== w[0] || b !== w[1]) win_bad[w] = 1'b1;
            if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) ctl_bad = 1'b1;
            if (k == 20) begin
                start    = 1'b1;
                expected = 4'b1111;
            end
            if (k == 21) start = 1'b0;
            @(negedge clk);
        end
        check("t5_window_00", {31'd0, win_bad[0]}, 0);
        check("t5_window_10", {31'd0, win_bad[1]}, 0);
        check("t5_window_01", {31'd0, win_bad[2]}, 0);
        check("t5_window_11", {31'd0, win_bad[3]}, 0);
        check("t5_busy_flags", {31'd0, ctl_bad}, 0);
        wait_done("t5_done");
        expected = 4'b0001;

        // Reset during vector 2 with partial failures accumulated
        mode = 2'd2;
        pulse_start(1'b0, 4'b0000, 3'd0, 1'b0);
        idle_cycles(27);
        check("t6_vector2", {a, b, busy, fail_mask}, {1'b0, 1'b1, 1'b1, 4'b0010});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", {a, b, busy, done, pass, fail_mask, fail_count}, 0);
        idle_cycles(2);
        check("t6_held_reset", {a, b, busy, done, pass, fail_mask, fail_count}, 0);
        rst_n = 1'b1;
        mode  = 2'd0;
        idle_cycles(2);
        check("t6_idle_after", {busy, done}, 0);
        pulse_start(1'b1, 4'b0000, 3'd0, 1'b1);
        wait_done("t6_done");

        idle_cycles(2);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
